z3_slave_ctrl: RTL
==================

Z3_SLAVE_CTRL -- requirements
Module: z3_slave_ctrl

Interface
REQ-001 SHALL have parameter NREG, default 4: number of decoded regions (1..8).
REQ-002 SHALL have parameter WAIT_W, default 4: width of each per-region wait-state count.
REQ-003 SHALL have parameter TIMEOUT, default 255: number of DATA-state cycles before a bus error (1..65535).
REQ-004 SHALL have port CLK  in  1  bus clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  in  1  synchronous reset, active-high.
REQ-006 SHALL have port FCS_n  in  1  Zorro III full cycle strobe; asynchronous to CLK.
REQ-007 SHALL have port DS_n  in  4  data strobes; asynchronous to CLK.
REQ-008 SHALL have port MTCR_n  in  1  multiple-transfer strobe; asynchronous to CLK.
REQ-009 SHALL have port A  in  32  bus address.
REQ-010 SHALL have ports READ, DOE  in  1 each  Zorro read qualifier and data output enable.
REQ-011 SHALL have port FC  in  3  function code.
REQ-012 SHALL have ports region_base and region_mask  in  NREG*8 each  per-region compare value and mask for A[31:24].
REQ-013 SHALL have port region_en  in  NREG  per-region enable.
REQ-014 SHALL have port region_wait  in  NREG*WAIT_W  per-region wait states.
REQ-015 SHALL have port region_ack  in  NREG  per-region ready.
REQ-016 SHALL have port sel  out  NREG  one-hot selected region.
REQ-017 SHALL have port addr  out  28  latched A[27:0].
REQ-018 SHALL have ports dtack, berr, busy  out  1 each.
REQ-019 SHALL have port xfer_count  out  8  completed data phases in the current cycle.

Function
REQ-020 SHALL synchronise FCS_n, DS_n and MTCR_n through two flops each; every stage resets to 1.
REQ-021 SHALL sample A into addr on each edge while the first FCS_n sync stage is 1, and SHALL hold addr while that stage is 0.
REQ-022 SHALL resample addr[7:0] from A on every edge while in MTGAP.
REQ-023 SHALL compute hit_i = region_en[i] && ((A[31:24] & mask_i) == (base_i & mask_i)); the lowest hitting index wins; validspace = FC[1]^FC[0].
REQ-024 SHALL implement states IDLE, START, DATA, END, MTGAP and ERR; in every non-IDLE state, synchronised FCS_n high SHALL force IDLE on the next edge with dtack and berr 0.
REQ-025 IDLE SHALL move to START and register sel one-hot when synchronised FCS_n is 0, any hit is true and validspace is 1; otherwise it SHALL stay in IDLE with sel 0.
REQ-026 START SHALL move to DATA when READ, or when any synchronised DS is 0 and DOE is 1.
REQ-027 On every entry to DATA, the block SHALL load the wait counter with region_wait[sel] and clear the timeout counter.
REQ-028 In DATA, a nonzero wait counter SHALL decrement; at zero with region_ack[sel] = 1, the next state SHALL be END and xfer_count SHALL increment, saturating at 255.
REQ-029 In DATA, the timeout counter SHALL increment every cycle; when it reaches TIMEOUT-1 with no exit, the next state SHALL be ERR, with ack-to-END taking precedence on the same edge.
REQ-030 END SHALL hold dtack = 1 and SHALL move to MTGAP when synchronised MTCR_n is 0 and all synchronised DS are 1.
REQ-031 MTGAP SHALL hold dtack = 0 and SHALL move to DATA when any synchronised DS is 0.
REQ-032 ERR SHALL hold berr = 1 and dtack = 0 until FCS_n is released.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 xfer_count SHALL clear on entry to START.
REQ-035 region_wait = 0 SHALL give a minimum DATA-to-END latency of 1 cycle when ack is already high.

Reset
REQ-036 While RESET = 1, on each edge the block SHALL be in IDLE with sel = 0, addr = 0, dtack = 0, berr = 0, busy = 0, xfer_count = 0, both counters at 0 and all sync flops at 1.
REQ-037 RESET SHALL take priority over every transition, including reset mid-cycle in END or MTGAP.

Verification
REQ-038 Bench SHALL cover a read at A = 0x4010_0020, region 1 with base 0x40 and mask 0xF0, wait = 2, ack held high -> sel = 0010, dtack rises exactly 3 CLK after DATA entry, and addr = 0x010_0020.
REQ-039 Bench SHALL cover regions 0 and 2 both matching -> sel = 0001; FC = 3'b000 or 3'b011 -> no START.
REQ-040 Bench SHALL cover a write with DOE held low for 5 cycles, then DOE high with DS_n = 0000 -> START is held 5 cycles, then DATA.
REQ-041 Bench SHALL cover 3 MTCR_n/DS_n strobes within one FCS_n low period, with A[7:0] = 0x00/0x04/0x08 -> three dtack pulses, xfer_count = 3, addr[7:0] tracks each value.
REQ-042 Bench SHALL cover TIMEOUT = 16 with region_ack stuck at 0 -> berr asserts after 16 DATA cycles, and IDLE follows 2 cycles after FCS_n rises.
REQ-043 Bench SHALL cover RESET pulsed for 1 cycle while in END -> next edge gives IDLE with dtack = 0 and busy = 0.

Source files
------------

// File: rtl/z3_slave_ctrl.sv
// Zorro III slave cycle controller: region decode, strobe synchronisation, DTACK/BERR generation.
// Latency: 2 CLK strobe synchronisation, START one edge after sync; DATA->END after region_wait+1 CLK.
// Backpressure: wait states and region_ack stall DATA; TIMEOUT DATA cycles without ack end in ERR (berr).
//
// Ports: CLK/RESET (sync, active-high); FCS_n, DS_n, MTCR_n async bus strobes; A, READ, DOE, FC bus
// qualifiers; region_* per-region decode/timing config; sel one-hot region, addr latched A[27:0],
// dtack/berr/busy cycle status, xfer_count data phases completed in the current cycle.
module z3_slave_ctrl #(
    parameter int NREG    = 4,
    parameter int WAIT_W  = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     FCS_n,
    input  logic [3:0]               DS_n,
    input  logic                     MTCR_n,
    input  logic [31:0]              A,
    input  logic                     READ,
    input  logic                     DOE,
    input  logic [2:0]               FC,
    input  logic [NREG*8-1:0]        region_base,
    input  logic [NREG*8-1:0]        region_mask,
    input  logic [NREG-1:0]          region_en,
    input  logic [NREG*WAIT_W-1:0]   region_wait,
    input  logic [NREG-1:0]          region_ack,
    output logic [NREG-1:0]          sel,
    output logic [27:0]              addr,
    output logic                     dtack,
    output logic                     berr,
    output logic                     busy,
    output logic [7:0]               xfer_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_END   = 3'd3,
        ST_MTGAP = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;

    // Two-flop synchronisers; idle bus level is 1 so every stage resets to 1.
    logic                fcs_s1, fcs_s2;
    logic [3:0]          ds_s1, ds_s2;
    logic                mtcr_s1, mtcr_s2;

    logic [NREG-1:0]     hit;
    logic [NREG-1:0]     hit_oh;
    logic                hit_any;
    logic                validspace;
    logic [WAIT_W-1:0]   wait_sel;
    logic                ack_sel;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [15:0]         to_cnt;
    logic                ds_any_low;
    logic                ds_all_high;
    logic                data_entry;

    // FC[2] distinguishes user/supervisor and plays no part in decoding.
    logic                unused_fc2;
    assign unused_fc2 = FC[2];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fcs_s1  <= 1'b1;
            fcs_s2  <= 1'b1;
            ds_s1   <= 4'hF;
            ds_s2   <= 4'hF;
            mtcr_s1 <= 1'b1;
            mtcr_s2 <= 1'b1;
        end else begin
            fcs_s1  <= FCS_n;
            fcs_s2  <= fcs_s1;
            ds_s1   <= DS_n;
            ds_s2   <= ds_s1;
            mtcr_s1 <= MTCR_n;
            mtcr_s2 <= mtcr_s1;
        end
    end

    assign ds_any_low  = ~&ds_s2;
    assign ds_all_high = &ds_s2;
    assign validspace  = FC[1] ^ FC[0];

    // Region compare on the live address; lowest index wins when several match.
    always_comb begin
        hit     = '0;
        hit_oh  = '0;
        hit_any = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            hit[i] = region_en[i] &&
                     ((A[31:24] & region_mask[i*8 +: 8]) == (region_base[i*8 +: 8] & region_mask[i*8 +: 8]));
        end
        for (int i = 0; i < NREG; i++) begin
            if (hit[i] && !hit_any) begin
                hit_oh[i] = 1'b1;
                hit_any   = 1'b1;
            end
        end
    end

    // sel is one-hot, so OR-ing the selected slices is a mux.
    always_comb begin
        wait_sel = '0;
        ack_sel  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (sel[i]) begin
                wait_sel = wait_sel | region_wait[i*WAIT_W +: WAIT_W];
                ack_sel  = ack_sel | region_ack[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (!fcs_s2 && hit_any && validspace) state_nxt = ST_START;
            ST_START: if (READ || (ds_any_low && DOE))      state_nxt = ST_DATA;
            ST_DATA: begin
                // Ack beats timeout when both happen on the same edge.
                if (wait_cnt == '0 && ack_sel)  state_nxt = ST_END;
                else if (to_cnt == TO_LAST)     state_nxt = ST_ERR;
            end
            ST_END:   if (!mtcr_s2 && ds_all_high)      state_nxt = ST_MTGAP;
            ST_MTGAP: if (ds_any_low)                    state_nxt = ST_DATA;
            ST_ERR:   state_nxt = ST_ERR;
            default:  state_nxt = ST_IDLE;
        endcase
        // Releasing FCS_n aborts whatever is in progress.
        if (state != ST_IDLE && fcs_s2) state_nxt = ST_IDLE;
    end

    assign data_entry = (state_nxt == ST_DATA) && (state != ST_DATA);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= ST_IDLE;
            sel        <= '0;
            wait_cnt   <= '0;
            to_cnt     <= '0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_IDLE && state_nxt == ST_START) sel <= hit_oh;
            else if (state_nxt == ST_IDLE)                 sel <= '0;

            if (data_entry) begin
                wait_cnt <= wait_sel;
                to_cnt   <= '0;
            end else if (state == ST_DATA) begin
                if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                to_cnt <= to_cnt + 16'd1;
            end

            if (state == ST_IDLE && state_nxt == ST_START)
                xfer_count <= '0;
            else if (state == ST_DATA && state_nxt == ST_END && xfer_count != 8'hFF)
                xfer_count <= xfer_count + 8'd1;
        end
    end

    // Address phase: track A until FCS_n is seen low, then hold; multi-transfer
    // gaps refresh only the low byte for the next beat.
    always_ff @(posedge CLK) begin
        if (RESET)                  addr      <= '0;
        else if (fcs_s1)            addr      <= A[27:0];
        else if (state == ST_MTGAP) addr[7:0] <= A[7:0];
    end

    assign dtack = (state == ST_END);
    assign berr  = (state == ST_ERR);
    assign busy  = (state != ST_IDLE);

endmodule
